// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one word-wide RAM port between instruction fetch and load/store,
// doing read-modify-write for sub-word stores and lane extraction for sub-word loads.
module mem_arbiter #(
    parameter int ADDR_WIDTH  = 14,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_IReq,
    input  logic [ADDR_WIDTH-1:0] in_IAddr,
    output logic                  out_IDone,
    output logic [31:0]           out_IData,
    input  logic                  in_DReq,
    input  logic                  in_DWrite,
    input  logic [1:0]            in_DSize,
    input  logic                  in_DSigned,
    input  logic [ADDR_WIDTH-1:0] in_DAddr,
    input  logic [31:0]           in_DWdata,
    output logic                  out_DDone,
    output logic [31:0]           out_DData,
    output logic                  out_DErr,
    output logic [ADDR_WIDTH-1:0] out_MemAddr,
    output logic                  out_MemWrite,
    output logic [1:0]            out_MemSize,
    output logic [31:0]           out_MemWdata,
    input  logic [31:0]           in_MemRdata,
    output logic                  out_Busy
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ERR   = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
    localparam logic [2:0] S_MERGE = 3'd4;
    localparam logic [2:0] S_WRITE = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            size_q, size_d;
    logic                  signed_q, signed_d;
    logic                  write_q, write_d;
    logic                  port_q, port_d;
    logic                  last_q, last_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           idata_q, idata_d;
    logic [31:0]           ddata_q, ddata_d;

    logic        d_bad, d_win, mem_act, d_resp;
    logic [4:0]  shift;
    logic [31:0] lane_mask, merged, load_val;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // port_q/last_q: 1 = data port, 0 = fetch port
    always_comb begin
        d_bad = (in_DSize == 2'b11) || (in_DSize == 2'b01 && in_DAddr[0]) ||
                (in_DSize == 2'b10 && in_DAddr[1:0] != 2'b00);
        d_win = in_DReq && (!in_IReq || !ROUND_ROBIN || !last_q);
        shift = (size_q == 2'b00) ? {addr_q[1:0], 3'b000} : {addr_q[1], 4'b0000};
        lane_mask = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << shift;
        merged = (in_MemRdata & ~lane_mask) | ((wdata_q << shift) & lane_mask);
        ld_byte = 8'(in_MemRdata >> shift);
        ld_half = 16'(in_MemRdata >> shift);
        load_val = (size_q == 2'b00) ? {{24{signed_q & ld_byte[7]}}, ld_byte} :
                   (size_q == 2'b01) ? {{16{signed_q & ld_half[15]}}, ld_half} : in_MemRdata;
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        signed_d = signed_q;
        write_d  = write_q;
        port_d   = port_q;
        last_d   = last_q;
        wdata_d  = wdata_q;
        idata_d  = idata_q;
        ddata_d  = ddata_q;
        case (state_q)
            S_IDLE: begin
                if (d_win) begin
                    port_d   = 1'b1;
                    last_d   = 1'b1;
                    addr_d   = in_DAddr;
                    size_d   = in_DSize;
                    signed_d = in_DSigned;
                    write_d  = in_DWrite;
                    wdata_d  = in_DWdata;
                    state_d  = d_bad ? S_ERR : (in_DWrite && in_DSize == 2'b10) ? S_WRITE : S_READ;
                end else if (in_IReq) begin
                    port_d   = 1'b0;
                    last_d   = 1'b0;
                    addr_d   = in_IAddr;
                    size_d   = 2'b10;
                    signed_d = 1'b0;
                    write_d  = 1'b0;
                    state_d  = S_READ;
                end
            end
            S_READ:  state_d = write_q ? S_MERGE : S_RESP;
            S_RESP: begin
                state_d = S_IDLE;
                idata_d = port_q ? idata_q : in_MemRdata;
                ddata_d = port_q ? load_val : ddata_q;
            end
            S_MERGE, S_WRITE: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            write_q  <= 1'b0;
            port_q   <= 1'b0;
            last_q   <= 1'b0;
            wdata_q  <= '0;
            idata_q  <= '0;
            ddata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            write_q  <= write_d;
            port_q   <= port_d;
            last_q   <= last_d;
            wdata_q  <= wdata_d;
            idata_q  <= idata_d;
            ddata_q  <= ddata_d;
        end
    end

    // RAM controls decode straight from state so an async reset silences a pending write
    assign mem_act      = (state_q == S_READ) || (state_q == S_WRITE) || (state_q == S_MERGE);
    assign d_resp       = (state_q == S_RESP) && port_q;
    assign out_MemAddr  = mem_act ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign out_MemWrite = (state_q == S_WRITE) || (state_q == S_MERGE);
    assign out_MemSize  = mem_act ? 2'b10 : 2'b11;
    assign out_MemWdata = (state_q == S_WRITE) ? wdata_q : (state_q == S_MERGE) ? merged : '0;
    assign out_IDone    = (state_q == S_RESP) && !port_q;
    assign out_IData    = out_IDone ? in_MemRdata : idata_q;
    assign out_DDone    = d_resp || (state_q == S_DONE) || (state_q == S_ERR);
    assign out_DData    = d_resp ? load_val : ddata_q;
    assign out_DErr     = (state_q == S_ERR);
    assign out_Busy     = (state_q != S_IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives directed transactions into two arbiters (round-robin and data-priority)
// backed by word RAM models, comparing every cycle against a transaction-level model.
module tb_mem_arbiter;
    logic        clock, reset_n;
    logic        i_req, d_req, d_write, d_signed;
    logic [13:0] i_addr, d_addr;
    logic [1:0]  d_size;
    logic [31:0] d_wdata;

    logic        i_done, d_done, d_err, m_wr, busy;
    logic [31:0] i_data, d_data, m_wd, m_rd;
    logic [13:0] m_addr;
    logic [1:0]  m_sz;
    logic        i_done0, d_done0, d_err0, m_wr0, busy0;
    logic [31:0] i_data0, d_data0, m_wd0, m_rd0;
    logic [13:0] m_addr0;
    logic [1:0]  m_sz0;

    logic [31:0] ram1 [4096];
    logic [31:0] ram0 [4096];
    logic [31:0] ref_mem [4096];

    logic [31:0] exp_i [int];
    logic [31:0] exp_d [int];
    logic [31:0] exp_a [int];
    logic [31:0] exp_w [int];
    bit          exp_e [int];
    bit          exp_b [int];
    logic [31:0] m_dd;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    bit chk1 = 1'b1;
    bit chk0 = 1'b1;

    mem_arbiter #(.ADDR_WIDTH(14), .ROUND_ROBIN(1'b1)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_IReq(i_req), .in_IAddr(i_addr), .out_IDone(i_done), .out_IData(i_data),
        .in_DReq(d_req), .in_DWrite(d_write), .in_DSize(d_size), .in_DSigned(d_signed),
        .in_DAddr(d_addr), .in_DWdata(d_wdata), .out_DDone(d_done), .out_DData(d_data),
        .out_DErr(d_err), .out_MemAddr(m_addr), .out_MemWrite(m_wr), .out_MemSize(m_sz),
        .out_MemWdata(m_wd), .in_MemRdata(m_rd), .out_Busy(busy)
    );

    mem_arbiter #(.ADDR_WIDTH(14), .ROUND_ROBIN(1'b0)) dut0 (
        .clock(clock), .reset_n(reset_n),
        .in_IReq(i_req), .in_IAddr(i_addr), .out_IDone(i_done0), .out_IData(i_data0),
        .in_DReq(d_req), .in_DWrite(d_write), .in_DSize(d_size), .in_DSigned(d_signed),
        .in_DAddr(d_addr), .in_DWdata(d_wdata), .out_DDone(d_done0), .out_DData(d_data0),
        .out_DErr(d_err0), .out_MemAddr(m_addr0), .out_MemWrite(m_wr0), .out_MemSize(m_sz0),
        .out_MemWdata(m_wd0), .in_MemRdata(m_rd0), .out_Busy(busy0)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // word RAMs: read data appears the cycle after the read is issued
    always @(posedge clock) begin
        if (m_sz == 2'b10) begin
            if (m_wr) ram1[m_addr[13:2]] <= m_wd;
            else m_rd <= ram1[m_addr[13:2]];
        end
        if (m_sz0 == 2'b10) begin
            if (m_wr0) ram0[m_addr0[13:2]] <= m_wd0;
            else m_rd0 <= ram0[m_addr0[13:2]];
        end
    end

    task automatic ck(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // transaction-level model: schedules expected outputs per cycle from the operation's rules
    task automatic predict(input bit is_d, input bit wr, input logic [1:0] sz, input bit sg,
                           input logic [13:0] a, input logic [31:0] wd, input int c, output int lat);
        logic [31:0] word, val;
        logic [31:0] al;
        int lane, n;
        al = 32'({a[13:2], 2'b00});
        word = ref_mem[a[13:2]];
        if (is_d && (sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00))) begin
            lat = 1;
            exp_b[c+1] = 1'b1;
            exp_d[c+1] = m_dd;
            exp_e[c+1] = 1'b1;
        end else if (is_d && wr && sz == 2'b10) begin
            lat = 2;
            exp_a[c+1] = al;
            exp_w[c+1] = wd;
            ref_mem[a[13:2]] = wd;
            exp_b[c+1] = 1'b1;
            exp_b[c+2] = 1'b1;
            exp_d[c+2] = m_dd;
        end else if (is_d && wr) begin
            n = (sz == 2'b00) ? 1 : 2;
            lane = (sz == 2'b00) ? int'(a[1:0]) : 2 * int'(a[1]);
            val = word;
            for (int i = 0; i < n; i++) val[8*(lane+i) +: 8] = wd[8*i +: 8];
            lat = 3;
            exp_a[c+1] = al;
            exp_a[c+2] = al;
            exp_w[c+2] = val;
            ref_mem[a[13:2]] = val;
            for (int i = 1; i <= 3; i++) exp_b[c+i] = 1'b1;
            exp_d[c+3] = m_dd;
        end else begin
            if (!is_d || sz == 2'b10) val = word;
            else if (sz == 2'b00) begin
                val = (word >> (8 * int'(a[1:0]))) & 32'hFF;
                if (sg && val[7]) val = val - 32'h100;
            end else begin
                val = (word >> (16 * int'(a[1]))) & 32'hFFFF;
                if (sg && val[15]) val = val - 32'h10000;
            end
            lat = 2;
            exp_a[c+1] = al;
            exp_b[c+1] = 1'b1;
            exp_b[c+2] = 1'b1;
            if (is_d) begin
                exp_d[c+2] = val;
                m_dd = val;
            end else exp_i[c+2] = val;
        end
    endtask

    task automatic cmp(input string tag, input logic idn, input logic [31:0] idt, input logic ddn,
                       input logic [31:0] ddt, input logic der, input logic [13:0] ma, input logic mw,
                       input logic [1:0] ms, input logic [31:0] mwd, input logic bz);
        ck({tag, ".idone"}, 32'(idn), 32'(exp_i.exists(cyc)));
        if (exp_i.exists(cyc)) ck({tag, ".idata"}, idt, exp_i[cyc]);
        ck({tag, ".ddone"}, 32'(ddn), 32'(exp_d.exists(cyc)));
        if (exp_d.exists(cyc)) ck({tag, ".ddata"}, ddt, exp_d[cyc]);
        ck({tag, ".derr"}, 32'(der), 32'(exp_e.exists(cyc)));
        ck({tag, ".memsize"}, 32'(ms), exp_a.exists(cyc) ? 32'd2 : 32'd3);
        if (exp_a.exists(cyc)) ck({tag, ".memaddr"}, 32'(ma), exp_a[cyc]);
        ck({tag, ".memwrite"}, 32'(mw), 32'(exp_w.exists(cyc)));
        if (exp_w.exists(cyc)) ck({tag, ".memwdata"}, mwd, exp_w[cyc]);
        ck({tag, ".busy"}, 32'(bz), 32'(exp_b.exists(cyc)));
    endtask

    always @(negedge clock) begin
        if (chk1) cmp("rr1", i_done, i_data, d_done, d_data, d_err, m_addr, m_wr, m_sz, m_wd, busy);
        if (chk0) cmp("rr0", i_done0, i_data0, d_done0, d_data0, d_err0, m_addr0, m_wr0, m_sz0, m_wd0, busy0);
    end

    task automatic txn(input bit is_d, input bit wr, input logic [1:0] sz, input bit sg,
                       input logic [13:0] a, input logic [31:0] wd);
        int lat;
        @(posedge clock);
        #1;
        predict(is_d, wr, sz, sg, a, wd, cyc, lat);
        if (is_d) begin
            d_req = 1'b1; d_write = wr; d_size = sz; d_signed = sg; d_addr = a; d_wdata = wd;
        end else begin
            i_req = 1'b1; i_addr = a;
        end
        repeat (lat) @(posedge clock);
        @(negedge clock);
        d_req = 1'b0;
        i_req = 1'b0;
    endtask

    task automatic reset_checks();
        ck("rst.idone", 32'(i_done), 32'd0);
        ck("rst.ddone", 32'(d_done), 32'd0);
        ck("rst.derr", 32'(d_err), 32'd0);
        ck("rst.busy", 32'(busy), 32'd0);
        ck("rst.idata", i_data, 32'd0);
        ck("rst.ddata", d_data, 32'd0);
        ck("rst.memaddr", 32'(m_addr), 32'd0);
        ck("rst.memwdata", m_wd, 32'd0);
        ck("rst.memwrite", 32'(m_wr), 32'd0);
        ck("rst.memsize", 32'(m_sz), 32'd3);
    endtask

    task automatic rst_pulse();
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        i_req = 1'b0;
        d_req = 1'b0;
        #1;
        reset_checks();
        #1;
        reset_n = 1'b1;
        m_dd = 32'd0;
    endtask

    initial begin
        reset_n = 1'b1;
        {i_req, d_req, d_write, d_signed} = '0;
        i_addr = '0; d_addr = '0; d_size = 2'b00; d_wdata = '0;
        m_dd = 32'd0;
        #1 reset_n = 1'b0;
        @(posedge clock);
        #3;
        reset_checks();
        #1 reset_n = 1'b1;

        txn(1, 1, 2'b10, 0, 14'h010, 32'hDEADBEEF);
        txn(1, 1, 2'b10, 0, 14'h020, 32'h80FF7F01);
        txn(1, 1, 2'b10, 0, 14'h040, 32'h11223344);
        txn(1, 1, 2'b10, 0, 14'h044, 32'h00000000);
        txn(1, 1, 2'b10, 0, 14'h048, 32'hCAFEF00D);

        txn(0, 0, 2'b10, 0, 14'h010, 32'h0);
        ck("lit.fetch", i_data, 32'hDEADBEEF);
        txn(0, 0, 2'b10, 0, 14'h013, 32'h0);
        ck("lit.fetch_low_bits", i_data, 32'hDEADBEEF);

        txn(1, 0, 2'b00, 1, 14'h023, 32'h0);
        ck("lit.sbyte", d_data, 32'hFFFFFF80);
        txn(1, 0, 2'b00, 0, 14'h021, 32'h0);
        ck("lit.ubyte", d_data, 32'h0000007F);
        txn(1, 0, 2'b01, 1, 14'h022, 32'h0);
        ck("lit.shalf", d_data, 32'hFFFF80FF);
        txn(1, 0, 2'b01, 0, 14'h020, 32'h0);
        ck("lit.uhalf", d_data, 32'h00007F01);

        txn(1, 1, 2'b00, 0, 14'h042, 32'h123456AA);
        ck("lit.bstore_done", 32'(d_done), 32'd1);
        txn(1, 0, 2'b10, 0, 14'h040, 32'h0);
        ck("lit.bstore_rmw", d_data, 32'h11AA3344);
        txn(1, 1, 2'b01, 0, 14'h046, 32'hDEADBEEF);
        txn(1, 0, 2'b10, 0, 14'h044, 32'h0);
        ck("lit.hstore", d_data, 32'hBEEF0000);

        txn(1, 1, 2'b01, 0, 14'h045, 32'h12345678);
        ck("lit.err_misaligned", 32'(d_err), 32'd1);
        ck("lit.err_keeps_ddata", d_data, 32'hBEEF0000);
        txn(1, 0, 2'b11, 0, 14'h040, 32'h0);
        txn(1, 0, 2'b10, 0, 14'h042, 32'h0);

        // byte store aborted by reset during its merge cycle
        @(posedge clock);
        #1;
        exp_a[cyc+1] = 32'h048;
        exp_b[cyc+1] = 1'b1;
        d_req = 1'b1; d_write = 1'b1; d_size = 2'b00; d_signed = 1'b0; d_addr = 14'h049; d_wdata = 32'h55;
        @(posedge clock);
        rst_pulse();
        txn(1, 0, 2'b10, 0, 14'h048, 32'h0);
        ck("lit.aborted_store", d_data, 32'hCAFEF00D);

        // both ports held: round-robin alternates D, I, D, I
        rst_pulse();
        chk0 = 1'b0;
        @(posedge clock);
        #1;
        for (int k = 0; k < 4; k++) begin
            int lat;
            predict(k % 2 == 0, 0, 2'b10, 0, (k % 2 == 0) ? 14'h020 : 14'h010, 32'h0, cyc + 3 * k, lat);
        end
        i_req = 1'b1; i_addr = 14'h010;
        d_req = 1'b1; d_write = 1'b0; d_size = 2'b10; d_signed = 1'b0; d_addr = 14'h020;
        repeat (11) @(posedge clock);
        @(negedge clock);
        ck("lit.rr_last_fetch", i_data, 32'hDEADBEEF);
        i_req = 1'b0;
        d_req = 1'b0;

        // data-priority instance starves fetch until the data request drops
        rst_pulse();
        chk1 = 1'b0;
        chk0 = 1'b1;
        @(posedge clock);
        #1;
        for (int k = 0; k < 4; k++) begin
            int lat;
            predict(k < 3, 0, 2'b10, 0, (k < 3) ? 14'h020 : 14'h010, 32'h0, cyc + 3 * k, lat);
        end
        i_req = 1'b1; i_addr = 14'h010;
        d_req = 1'b1; d_write = 1'b0; d_size = 2'b10; d_signed = 1'b0; d_addr = 14'h020;
        repeat (8) @(posedge clock);
        @(negedge clock);
        d_req = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        ck("lit.prio_fetch", i_data0, 32'hDEADBEEF);
        i_req = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
